// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: alignment check, byte-lane bus driver with watchdog,
// and sign/zero extension of load data.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | bus request outstanding, waiting for mem_ack or watchdog expiry
// RESP   | one-cycle response pulse, then back to IDLE
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic                busy
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam bit WDOG_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state;
  logic [2:0]         op_q;
  logic [OFF_W-1:0]   off_q;
  logic [CNT_W-1:0]   wdog_cnt;

  logic [OFF_W-1:0]   req_off;
  logic [OFF_W-1:0]   size_mask;
  logic [3:0]         acc_size;
  logic               op_ok;
  logic               req_bad;
  logic [NB-1:0]      req_be;
  logic [DATA_W-1:0]  req_wrep;
  logic [ADDR_W-1:0]  req_aligned;
  logic [DATA_W-1:0]  lane;
  logic [DATA_W-1:0]  ext;

  // Request decode: access size, legality, byte enables and replicated store data.
  always_comb begin
    req_off  = req_addr[OFF_W-1:0];
    op_ok    = 1'b1;
    acc_size = 4'd1;
    case (req_op)
      3'd0:       acc_size = 4'(NB);
      3'd1, 3'd2: acc_size = 4'd1;
      3'd3, 3'd4: acc_size = 4'd2;
      3'd5, 3'd6: begin
        acc_size = 4'd4;
        op_ok    = (DATA_W == 64);
      end
      default:    op_ok = 1'b0;
    endcase
    size_mask   = OFF_W'(acc_size - 4'd1);
    req_bad     = !op_ok || ((req_off & size_mask) != '0);
    req_aligned = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    req_be      = '0;
    req_wrep    = '0;
    for (int i = 0; i < NB; i++) begin
      req_be[i] = (i >= int'(req_off)) && (i < int'(req_off) + int'(acc_size));
      req_wrep[8*i +: 8] = req_wdata[8*(i & int'(size_mask)) +: 8];
    end
  end

  // Select the addressed field of the returned word and extend it.
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    ext  = mem_rdata;
    case (op_q)
      3'd1: begin ext = '0;                ext[7:0]  = lane[7:0];  end
      3'd2: begin ext = {DATA_W{lane[7]}};  ext[7:0]  = lane[7:0];  end
      3'd3: begin ext = '0;                ext[15:0] = lane[15:0]; end
      3'd4: begin ext = {DATA_W{lane[15]}}; ext[15:0] = lane[15:0]; end
      3'd5: begin ext = '0;                ext[31:0] = lane[31:0]; end
      3'd6: begin ext = {DATA_W{lane[31]}}; ext[31:0] = lane[31:0]; end
      default: ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 2'b00;
      op_q      <= '0;
      off_q     <= '0;
      wdog_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_bad) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 2'b01;
              rsp_rdata <= '0;
            end else begin
              state     <= ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= req_aligned;
              mem_be    <= req_be;
              mem_wdata <= req_wrep;
              op_q      <= req_op;
              off_q     <= req_off;
              wdog_cnt  <= CNT_LOAD;
            end
          end
        end
        ACCESS: begin
          // An ack in the expiry cycle takes priority over the watchdog.
          if (mem_ack) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 2'b00;
            rsp_rdata <= mem_we ? '0 : ext;
          end else if (WDOG_EN && (wdog_cnt == '0)) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 2'b10;
            rsp_rdata <= '0;
          end else begin
            wdog_cnt <= wdog_cnt - 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          mem_req   <= 1'b0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: 32- and 64-bit instances (watchdog of 4) driven by a
// shared stimulus path, with a directed vector table plus randomized transactions.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        sel64;
  logic        req_valid, req_we, mem_ack;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, mem_rdata;

  logic v32, v64, a32, a64;
  assign v32 = req_valid & ~sel64;
  assign v64 = req_valid & sel64;
  assign a32 = mem_ack & ~sel64;
  assign a64 = mem_ack & sel64;

  logic        rr32, mr32, mw32, rv32, b32;
  logic [31:0] ma32, wd32, rd32;
  logic [3:0]  be32;
  logic [1:0]  er32;
  logic        rr64, mr64, mw64, rv64, b64;
  logic [31:0] ma64;
  logic [63:0] wd64, rd64;
  logic [7:0]  be64;
  logic [1:0]  er64;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut32 (
    .clk(clk), .reset(reset), .req_valid(v32), .req_ready(rr32), .req_we(req_we),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .mem_req(mr32), .mem_we(mw32), .mem_addr(ma32), .mem_be(be32), .mem_wdata(wd32),
    .mem_ack(a32), .mem_rdata(mem_rdata[31:0]), .rsp_valid(rv32), .rsp_rdata(rd32),
    .rsp_err(er32), .busy(b32));

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO)) dut64 (
    .clk(clk), .reset(reset), .req_valid(v64), .req_ready(rr64), .req_we(req_we),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mr64), .mem_we(mw64), .mem_addr(ma64), .mem_be(be64), .mem_wdata(wd64),
    .mem_ack(a64), .mem_rdata(mem_rdata), .rsp_valid(rv64), .rsp_rdata(rd64),
    .rsp_err(er64), .busy(b64));

  logic        o_ready, o_mreq, o_mwe, o_rvalid, o_busy;
  logic [31:0] o_maddr;
  logic [7:0]  o_be;
  logic [63:0] o_wdata, o_rdata;
  logic [1:0]  o_err;

  always_comb begin
    o_ready  = sel64 ? rr64 : rr32;
    o_mreq   = sel64 ? mr64 : mr32;
    o_mwe    = sel64 ? mw64 : mw32;
    o_rvalid = sel64 ? rv64 : rv32;
    o_busy   = sel64 ? b64  : b32;
    o_maddr  = sel64 ? ma64 : ma32;
    o_be     = sel64 ? be64 : {4'b0, be32};
    o_wdata  = sel64 ? wd64 : {32'b0, wd32};
    o_rdata  = sel64 ? rd64 : {32'b0, rd32};
    o_err    = sel64 ? er64 : er32;
  end

  int checks = 0;
  int failures = 0;
  logic [63:0] prev_rd [2];
  logic [1:0]  prev_err [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: derived from access size, offset and ack timing with plain arithmetic.
  function automatic void model(input int dw, input logic [2:0] op, input logic [31:0] addr,
                                input bit we, input logic [63:0] wd, input logic [63:0] rd,
                                input int ackd, output logic [1:0] err, output logic [63:0] rdat,
                                output logic [7:0] be, output logic [63:0] wrep);
    int nb, size, off;
    bit legal;
    logic [127:0] field, mask;
    nb = dw / 8;
    off = int'(addr % nb);
    legal = 1;
    size = 1;
    case (op)
      3'd0: size = nb;
      3'd1, 3'd2: size = 1;
      3'd3, 3'd4: size = 2;
      3'd5, 3'd6: begin size = 4; legal = (dw == 64); end
      default: legal = 0;
    endcase
    mask  = (128'd1 << (8 * size)) - 128'd1;
    field = ({64'd0, rd} >> (8 * off)) & mask;
    if ((op == 3'd2 || op == 3'd4 || op == 3'd6) && field[8*size-1]) field = field | ~mask;
    if (dw == 32) field = field & 128'hFFFF_FFFF;
    be = 8'(((1 << size) - 1) << off);
    wrep = '0;
    for (int i = 0; i < nb; i++) wrep[8*i +: 8] = wd[8*(i % size) +: 8];
    if (!legal || (off % size) != 0) err = 2'b01;
    else if (ackd >= TO)             err = 2'b10;
    else                             err = 2'b00;
    rdat = (err != 2'b00 || we) ? 64'd0 : field[63:0];
  endfunction

  task automatic run_txn(input bit s64, input logic [2:0] op, input logic [31:0] addr,
                         input bit we, input logic [63:0] wd, input logic [63:0] rd,
                         input int ackd, input logic [1:0] e_err, input logic [63:0] e_rd,
                         input logic [7:0] e_be, input logic [63:0] e_wd);
    int idx, nb, k, exp_k;
    logic [31:0] e_addr;
    idx = s64 ? 1 : 0;
    nb  = s64 ? 8 : 4;
    e_addr = addr & ~(32'(nb - 1));
    @(negedge clk);
    sel64 = s64;
    #1;
    chk("idle_ready", 64'(o_ready), 64'd1);
    chk("idle_busy", 64'(o_busy), 64'd0);
    chk("idle_rvalid", 64'(o_rvalid), 64'd0);
    chk("hold_rdata", o_rdata, prev_rd[idx]);
    chk("hold_err", 64'(o_err), 64'(prev_err[idx]));
    req_valid = 1'b1; req_op = op; req_addr = addr; req_we = we; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (e_err == 2'b01) begin
      chk("err_no_memreq", 64'(o_mreq), 64'd0);
      chk("err_rvalid", 64'(o_rvalid), 64'd1);
      chk("err_code", 64'(o_err), 64'd1);
      chk("err_rdata", o_rdata, 64'd0);
    end else begin
      k = 0;
      do begin
        chk("acc_memreq", 64'(o_mreq), 64'd1);
        chk("acc_addr", 64'(o_maddr), 64'(e_addr));
        chk("acc_we", 64'(o_mwe), 64'(we));
        chk("acc_be", 64'(o_be), 64'(e_be));
        chk("acc_wdata", o_wdata, e_wd);
        if (k == ackd) begin mem_ack = 1'b1; mem_rdata = rd; end
        else begin mem_ack = 1'b0; mem_rdata = {$urandom, $urandom}; end
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        k++;
      end while (o_mreq && k < 40);
      exp_k = (e_err == 2'b10) ? TO : ackd + 1;
      chk("memreq_cycles", 64'(k), 64'(exp_k));
      chk("rsp_rvalid", 64'(o_rvalid), 64'd1);
      chk("rsp_err", 64'(o_err), 64'(e_err));
      chk("rsp_rdata", o_rdata, e_rd);
    end
    prev_rd[idx]  = e_rd;
    prev_err[idx] = e_err;
  endtask

  typedef struct {
    bit          s64;
    logic [2:0]  op;
    logic [31:0] addr;
    bit          we;
    logic [63:0] wd;
    logic [63:0] rd;
    int          ackd;
    logic [1:0]  err;
    logic [63:0] erd;
    logic [7:0]  ebe;
    logic [63:0] ewd;
  } vec_t;

  vec_t vecs [18];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [1:0]  m_err;
    logic [63:0] m_rd, m_wd, r_wd, r_rd;
    logic [7:0]  m_be;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    bit          r_s64, r_we;
    int          r_ackd;

    vecs[0]  = '{0, 3'd2, 32'h1003, 0, 64'h0, 64'h80FF7F01, 0, 2'b00, 64'hFFFFFF80, 8'h08, 64'h0};
    vecs[1]  = '{0, 3'd3, 32'h1002, 0, 64'h0, 64'h80FF7F01, 0, 2'b00, 64'h000080FF, 8'h0C, 64'h0};
    vecs[2]  = '{0, 3'd4, 32'h1000, 0, 64'h0, 64'h80FF7F01, 0, 2'b00, 64'h00007F01, 8'h03, 64'h0};
    vecs[3]  = '{0, 3'd1, 32'h1002, 1, 64'h123456AB, 64'hDEADBEEF, 0, 2'b00, 64'h0, 8'h04, 64'hABABABAB};
    vecs[4]  = '{0, 3'd0, 32'h1001, 1, 64'h11223344, 64'h0, 0, 2'b01, 64'h0, 8'h00, 64'h0};
    vecs[5]  = '{0, 3'd5, 32'h1000, 0, 64'h0, 64'h0, 0, 2'b01, 64'h0, 8'h00, 64'h0};
    vecs[6]  = '{0, 3'd0, 32'h2000, 0, 64'h0, 64'hCAFEF00D, 2, 2'b00, 64'hCAFEF00D, 8'h0F, 64'h0};
    vecs[7]  = '{0, 3'd1, 32'h2001, 0, 64'h0, 64'h0, 99, 2'b10, 64'h0, 8'h02, 64'h0};
    vecs[8]  = '{0, 3'd1, 32'h2001, 0, 64'h0, 64'h0000AB00, 3, 2'b00, 64'h000000AB, 8'h02, 64'h0};
    vecs[9]  = '{0, 3'd7, 32'h2000, 0, 64'h0, 64'h0, 0, 2'b01, 64'h0, 8'h00, 64'h0};
    vecs[10] = '{0, 3'd3, 32'h1001, 0, 64'h0, 64'h0, 0, 2'b01, 64'h0, 8'h00, 64'h0};
    vecs[11] = '{1, 3'd6, 32'h8004, 0, 64'h0, 64'h80000001_12345678, 0, 2'b00, 64'hFFFFFFFF_80000001, 8'hF0, 64'h0};
    vecs[12] = '{1, 3'd5, 32'h8004, 0, 64'h0, 64'h80000001_12345678, 1, 2'b00, 64'h00000000_80000001, 8'hF0, 64'h0};
    vecs[13] = '{1, 3'd0, 32'h8000, 1, 64'h11223344_55667788, 64'h0, 0, 2'b00, 64'h0, 8'hFF, 64'h11223344_55667788};
    vecs[14] = '{1, 3'd5, 32'h8004, 1, 64'hAAAABBBB_CCCCDDDD, 64'h0, 0, 2'b00, 64'h0, 8'hF0, 64'hCCCCDDDD_CCCCDDDD};
    vecs[15] = '{1, 3'd0, 32'h8004, 0, 64'h0, 64'h0, 0, 2'b01, 64'h0, 8'h00, 64'h0};
    vecs[16] = '{1, 3'd1, 32'h8007, 1, 64'h5A, 64'h0, 0, 2'b00, 64'h0, 8'h80, 64'h5A5A5A5A_5A5A5A5A};
    vecs[17] = '{1, 3'd4, 32'h8006, 0, 64'h0, 64'h8001_0000_0000_0000, 0, 2'b00, 64'hFFFFFFFF_FFFF8001, 8'hC0, 64'h0};

    reset = 1'b1; sel64 = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = '0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    prev_rd[0] = '0; prev_rd[1] = '0; prev_err[0] = '0; prev_err[1] = '0;
    repeat (2) @(posedge clk);
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      sel64 = (s == 1);
      #1;
      chk("rst_ready", 64'(o_ready), 64'd1);
      chk("rst_memreq", 64'(o_mreq), 64'd0);
      chk("rst_memwe", 64'(o_mwe), 64'd0);
      chk("rst_rvalid", 64'(o_rvalid), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_addr", 64'(o_maddr), 64'd0);
      chk("rst_be", 64'(o_be), 64'd0);
      chk("rst_wdata", o_wdata, 64'd0);
      chk("rst_rdata", o_rdata, 64'd0);
      chk("rst_err", 64'(o_err), 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++)
      run_txn(vecs[i].s64, vecs[i].op, vecs[i].addr, vecs[i].we, vecs[i].wd, vecs[i].rd,
              vecs[i].ackd, vecs[i].err, vecs[i].erd, vecs[i].ebe, vecs[i].ewd);

    // Stray ack while idle must be ignored.
    @(negedge clk);
    sel64 = 1'b0;
    mem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ack_rvalid", 64'(o_rvalid), 64'd0);
    chk("stray_ack_busy", 64'(o_busy), 64'd0);
    chk("stray_ack_memreq", 64'(o_mreq), 64'd0);

    // Reset in the second ACCESS cycle, followed by a late ack.
    sel64 = 1'b0; req_valid = 1'b1; req_op = 3'd2; req_addr = 32'h3000; req_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid_memreq_c1", 64'(o_mreq), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_memreq_c2", 64'(o_mreq), 64'd1);
    reset = 1'b1;
    #1;
    chk("rstmid_memreq_drop", 64'(o_mreq), 64'd0);
    chk("rstmid_ready", 64'(o_ready), 64'd1);
    chk("rstmid_rvalid", 64'(o_rvalid), 64'd0);
    mem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_rvalid", 64'(o_rvalid), 64'd0);
    chk("late_ack_busy", 64'(o_busy), 64'd0);
    prev_rd[0] = '0; prev_rd[1] = '0; prev_err[0] = '0; prev_err[1] = '0;

    for (int n = 0; n < 60; n++) begin
      r_s64  = 1'($urandom_range(0, 1));
      r_op   = 3'($urandom_range(0, 7));
      r_addr = $urandom;
      r_we   = 1'($urandom_range(0, 1));
      r_wd   = {$urandom, $urandom};
      r_rd   = {$urandom, $urandom};
      r_ackd = int'($urandom_range(0, 5));
      model(r_s64 ? 64 : 32, r_op, r_addr, r_we, r_wd, r_rd, r_ackd, m_err, m_rd, m_be, m_wd);
      run_txn(r_s64, r_op, r_addr, r_we, r_wd, r_rd, r_ackd, m_err, m_rd, m_be, m_wd);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
